// File: rtl/reset_sequencer_pkg.sv
// reset_seq_pkg
// Shared definitions for the CPU reset sequencer: FSM state encoding,
// reset-cause codes and a saturating counter helper.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        SETTLE    = 3'd1,
        HOLD      = 3'd2,
        RUN       = 3'd3,
        DRAIN     = 3'd4
    } state_t;

    localparam logic [1:0] CAUSE_POR  = 2'd1;
    localparam logic [1:0] CAUSE_BTN  = 2'd2;
    localparam logic [1:0] CAUSE_LOCK = 2'd3;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if
// Groups the sequencer's functional signals.
//   pll_locked : PLL lock (asynchronous)
//   reset_req  : single-cycle button reset request (clk domain)
//   reset_en   : switch level qualifying reset_req (asynchronous)
//   tx_idle    : UART transmitter has no frame in flight
//   cpu_rst    : registered active-high CPU reset
//   drain      : registered, high while waiting for the UART to drain
//   rst_cause  : cause of last reset (1 power-on, 2 button, 3 lock loss)
//   rst_count  : saturating count of button resets
// master = the surrounding top level, slave = the sequencer.
interface reset_sequencer_if;

    logic       pll_locked;
    logic       reset_req;
    logic       reset_en;
    logic       tx_idle;
    logic       cpu_rst;
    logic       drain;
    logic [1:0] rst_cause;
    logic [7:0] rst_count;

    modport master (
        output pll_locked, reset_req, reset_en, tx_idle,
        input  cpu_rst, drain, rst_cause, rst_count
    );

    modport slave (
        input  pll_locked, reset_req, reset_en, tx_idle,
        output cpu_rst, drain, rst_cause, rst_count
    );

endinterface

// File: rtl/reset_sequencer_sync_ff.sv
// sync_ff
// WIDTH-bit, STAGES-deep flop chain for bringing asynchronous levels into
// the clk domain. All stages reset asynchronously to 0.
//   clk, rst_n : clock, asynchronous active-low reset
//   d          : asynchronous input bits
//   q          : synchronized output (last stage)
module sync_ff #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer
// Owns the CPU reset line. Holds the CPU in reset until the PLL is locked
// and has settled, then turns qualified button requests into a fixed-length
// reset pulse, draining the UART first so no frame is cut mid-character.
//   clk, rst_n : CPU clock, asynchronous active-low reset
//   bus        : reset_sequencer_if.slave (see interface for signal list)
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned DRAIN_CYCLES  = 8192,
    parameter int unsigned CNT_W         = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    reset_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             locked_s;
    logic             reset_en_s;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;
    logic [7:0]       count_q, count_d;
    logic             cpu_rst_q;
    logic             drain_q;

    sync_ff #(
        .WIDTH  (2),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({bus.reset_en, bus.pll_locked}),
        .q     (sync_q)
    );

    assign locked_s   = sync_q[0];
    assign reset_en_s = sync_q[1];

    // Lock loss is tested first in every locked state so it always beats a
    // concurrent button request or drain completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        count_d = count_q;
        case (state_q)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    cause_d = CAUSE_LOCK;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    cause_d = CAUSE_LOCK;
                end else if (bus.reset_req && reset_en_s) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    cause_d = CAUSE_LOCK;
                end else if (bus.tx_idle || (cnt_q == DRAIN_LAST)) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    cause_d = CAUSE_BTN;
                    count_d = sat_inc8(count_q);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are derived from the next state so they change on the same
    // edge as the transition that defines them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            cause_q   <= CAUSE_POR;
            count_q   <= '0;
            cpu_rst_q <= 1'b1;
            drain_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
            count_q   <= count_d;
            cpu_rst_q <= !((state_d == RUN) || (state_d == DRAIN));
            drain_q   <= (state_d == DRAIN);
        end
    end

    assign bus.cpu_rst   = cpu_rst_q;
    assign bus.drain     = drain_q;
    assign bus.rst_cause = cause_q;
    assign bus.rst_count = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
// Directed scenarios plus a randomized phase for reset_sequencer, checked
// every cycle against a phase/countdown model of the sequencer behaviour,
// with hand-computed literal expectations at the key points.
module tb_reset_sequencer;

    localparam int unsigned SYNC   = 2;
    localparam int unsigned SETTLE = 4;
    localparam int unsigned HOLD   = 3;
    localparam int unsigned DRAINC = 10;

    logic clk;
    logic rst_n;

    reset_sequencer_if u_if ();

    reset_sequencer #(
        .SYNC_STAGES   (SYNC),
        .SETTLE_CYCLES (SETTLE),
        .HOLD_CYCLES   (HOLD),
        .DRAIN_CYCLES  (DRAINC),
        .CNT_W         (14)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // ---------------- behavioural model ----------------
    typedef enum int {M_OFF, M_SETTLE, M_HOLD, M_RUN, M_DRAIN} mphase_t;
    mphase_t          m_phase = M_OFF;
    int               m_left  = 0;
    int               m_cause = 1;
    int               m_count = 0;
    logic [SYNC-1:0]  lk_hist = '0;
    logic [SYNC-1:0]  en_hist = '0;

    initial begin : model
        logic ls;
        logic es;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_phase = M_OFF;
                m_left  = 0;
                m_cause = 1;
                m_count = 0;
                lk_hist = '0;
                en_hist = '0;
            end else begin
                // Value the sequencer sees now was sampled SYNC edges ago.
                ls = lk_hist[SYNC-1];
                es = en_hist[SYNC-1];
                lk_hist = {lk_hist[SYNC-2:0], u_if.pll_locked};
                en_hist = {en_hist[SYNC-2:0], u_if.reset_en};
                if (m_phase != M_OFF && !ls) begin
                    if (m_phase != M_SETTLE) m_cause = 3;
                    m_phase = M_OFF;
                end else begin
                    case (m_phase)
                        M_OFF: begin
                            if (ls) begin
                                m_phase = M_SETTLE;
                                m_left  = SETTLE;
                            end
                        end
                        M_SETTLE: begin
                            m_left--;
                            if (m_left == 0) begin
                                m_phase = M_HOLD;
                                m_left  = HOLD;
                            end
                        end
                        M_HOLD: begin
                            m_left--;
                            if (m_left == 0) m_phase = M_RUN;
                        end
                        M_RUN: begin
                            if (u_if.reset_req && es) begin
                                m_phase = M_DRAIN;
                                m_left  = DRAINC;
                            end
                        end
                        M_DRAIN: begin
                            m_left--;
                            if (u_if.tx_idle || m_left == 0) begin
                                m_phase = M_HOLD;
                                m_left  = HOLD;
                                m_cause = 2;
                                if (m_count < 255) m_count++;
                            end
                        end
                        default: m_phase = M_OFF;
                    endcase
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    task automatic compare_model();
        check("cpu_rst",   int'(u_if.cpu_rst),   (m_phase == M_RUN || m_phase == M_DRAIN) ? 0 : 1);
        check("drain",     int'(u_if.drain),     (m_phase == M_DRAIN) ? 1 : 0);
        check("rst_cause", int'(u_if.rst_cause), m_cause);
        check("rst_count", int'(u_if.rst_count), m_count);
    endtask

    // Advance one cycle; outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic wait_phase(input mphase_t p, input int limit, input string name);
        for (int i = 0; i < limit; i++) begin
            if (m_phase == p) return;
            step();
        end
        if (m_phase != p) fail_timeout(name);
    endtask

    // pll_locked rises before the next edge (k); cpu_rst must fall at k+9.
    task automatic power_up(input int exp_cause);
        u_if.pll_locked = 1'b1;
        for (int j = 0; j <= 9; j++) begin
            step();
            if (j == 8) check("pu_rst_k8", int'(u_if.cpu_rst), 1);
            if (j == 9) begin
                check("pu_rst_k9", int'(u_if.cpu_rst), 0);
                check("pu_cause",  int'(u_if.rst_cause), exp_cause);
                check("pu_drain",  int'(u_if.drain), 0);
            end
        end
    endtask

    // tx_idle is sampled 0 for idle_after DRAIN cycles, then 1.
    task automatic button(input int idle_after, input int exp_dwell, input int exp_count);
        int dwell;
        int hold;
        u_if.tx_idle   = (idle_after == 0);
        u_if.reset_req = 1'b1;
        step();
        u_if.reset_req = 1'b0;
        dwell = 0;
        for (int i = 0; i < 60 && u_if.drain; i++) begin
            dwell++;
            if (dwell == idle_after + 1) u_if.tx_idle = 1'b1;
            step();
        end
        u_if.tx_idle = 1'b1;
        check("drain_dwell", dwell, exp_dwell);
        check("btn_cause", int'(u_if.rst_cause), 2);
        check("btn_count", int'(u_if.rst_count), exp_count);
        hold = 0;
        for (int i = 0; i < 20 && u_if.cpu_rst; i++) begin
            hold++;
            step();
        end
        check("hold_len", hold, HOLD);
    endtask

    task automatic drop_lock_and_relock(input int exp_cause);
        u_if.pll_locked = 1'b0;
        wait_phase(M_OFF, 20, "wait_off");
        step();
        power_up(exp_cause);
    endtask

    initial begin : stim
        int bias;
        rst_n           = 1'b0;
        u_if.pll_locked = 1'b0;
        u_if.reset_req  = 1'b0;
        u_if.reset_en   = 1'b1;
        u_if.tx_idle    = 1'b1;
        step();
        step();
        check("rst_cpu_rst", int'(u_if.cpu_rst), 1);
        check("rst_cause0",  int'(u_if.rst_cause), 1);
        check("rst_count0",  int'(u_if.rst_count), 0);
        check("rst_drain0",  int'(u_if.drain), 0);
        rst_n = 1'b1;
        step();
        step();

        // Power-up
        power_up(1);
        step();

        // Button resets: idle UART, timeout, idle after 4 cycles
        button(0, 1, 1);
        button(1000, DRAINC, 2);
        button(4, 5, 3);

        // Gated request in RUN
        u_if.reset_en = 1'b0;
        repeat (4) step();
        u_if.reset_req = 1'b1;
        step();
        u_if.reset_req = 1'b0;
        repeat (4) step();
        check("gated_rst",   int'(u_if.cpu_rst), 0);
        check("gated_count", int'(u_if.rst_count), 3);
        u_if.reset_en = 1'b1;
        repeat (4) step();

        // Request during SETTLE is dropped
        u_if.pll_locked = 1'b0;
        wait_phase(M_OFF, 20, "settle_off");
        u_if.pll_locked = 1'b1;
        wait_phase(M_SETTLE, 20, "settle_enter");
        u_if.reset_req = 1'b1;
        step();
        u_if.reset_req = 1'b0;
        wait_phase(M_RUN, 30, "settle_run");
        step();
        check("settle_rst",   int'(u_if.cpu_rst), 0);
        check("settle_count", int'(u_if.rst_count), 3);

        // Lock loss during DRAIN
        u_if.tx_idle   = 1'b0;
        u_if.reset_req = 1'b1;
        step();
        u_if.reset_req = 1'b0;
        step();
        u_if.pll_locked = 1'b0;
        wait_phase(M_OFF, 10, "drain_lockloss");
        check("dl_rst",   int'(u_if.cpu_rst), 1);
        check("dl_drain", int'(u_if.drain), 0);
        check("dl_cause", int'(u_if.rst_cause), 3);
        check("dl_count", int'(u_if.rst_count), 3);
        u_if.tx_idle = 1'b1;
        step();
        power_up(3);
        step();

        // Lock loss seen on the same edge as a request
        u_if.pll_locked = 1'b0;
        step();
        step();
        u_if.reset_req = 1'b1;
        step();
        u_if.reset_req = 1'b0;
        check("ll_req_rst",   int'(u_if.cpu_rst), 1);
        check("ll_req_drain", int'(u_if.drain), 0);
        check("ll_req_cause", int'(u_if.rst_cause), 3);
        check("ll_req_count", int'(u_if.rst_count), 3);
        step();
        power_up(3);
        step();

        // Saturation
        for (int i = 0; i < 256; i++) begin
            button(0, 1, (3 + i + 1 > 255) ? 255 : 3 + i + 1);
        end
        check("sat_count", int'(u_if.rst_count), 255);

        // Async reset mid-HOLD, between edges
        u_if.reset_req = 1'b1;
        step();
        u_if.reset_req = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst",   int'(u_if.cpu_rst), 1);
        check("async_count", int'(u_if.rst_count), 0);
        check("async_cause", int'(u_if.rst_cause), 1);
        step();
        step();
        rst_n = 1'b1;
        power_up(1);

        // Randomized phase
        for (int blk = 0; blk < 6; blk++) begin
            bias = (blk % 2 == 0) ? 3 : 30;
            for (int c = 0; c < 500; c++) begin
                u_if.reset_req = ($urandom_range(0, 7) == 0);
                u_if.tx_idle   = ($urandom_range(0, bias) == 0);
                if ($urandom_range(0, 99) == 0) u_if.reset_en = ~u_if.reset_en;
                if (u_if.pll_locked) begin
                    if ($urandom_range(0, 299) == 0) u_if.pll_locked = 1'b0;
                end else begin
                    if ($urandom_range(0, 9) == 0) u_if.pll_locked = 1'b1;
                end
                step();
            end
        end
        u_if.reset_req = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Owns the CPU reset line in the top level.
- Holds the CPU in reset until the clock PLL reports lock and has settled. After that, it turns a qualified button reset request into a clean, fixed-length reset pulse.
- Before a button reset, it drains the UART transmitter so no serial frame is cut off mid-character.
- Sits between the clock wizard / button parser / switches and the CPU's active-high `rst`. It also reports the cause of the last reset and a reset count.

Parameters:
- SYNC_STAGES, 2: synchronizer depth for `pll_locked` and `reset_en`. Must be ≥ 2.
- SETTLE_CYCLES, 1024: cycles of continuous `locked_s` required before HOLD. Must be ≥ 1.
- HOLD_CYCLES, 16: cycles `cpu_rst` is held in the HOLD state. Must be ≥ 1.
- DRAIN_CYCLES, 8192: maximum cycles spent waiting for `tx_idle` before forcing reset. Must be ≥ 1.
- CNT_W, 14: width of the shared cycle counter. Must satisfy 2^CNT_W > max(SETTLE, HOLD, DRAIN).

Ports:
- clk  in  1  CPU clock.
- rst_n  in  1  Asynchronous, active-low reset.
- pll_locked  in  1  PLL lock. Asynchronous; synchronized internally to `locked_s`.
- reset_req  in  1  Single-cycle pulse in the `clk` domain (button parser output).
- reset_en  in  1  Switch level that qualifies `reset_req`. Synchronized internally to `reset_en_s`.
- tx_idle  in  1  1 = UART transmitter has no frame in flight.
- cpu_rst  out  1  Registered, active-high CPU reset.
- drain  out  1  Registered; 1 while in the DRAIN state.
- rst_cause  out  2  Cause of last reset: 1 = power-on, 2 = button, 3 = lock loss, 0 = unused.
- rst_count  out  8  Saturating count of button resets.

Behaviour:
- Async reset values (`rst_n` = 0):
  - state = WAIT_LOCK, counter = 0, synchronizer flops = 0.
  - `cpu_rst` = 1, `drain` = 0, `rst_cause` = 1, `rst_count` = 0.
  - These take effect immediately, without waiting for a clock edge.
- All outputs are flops. Each output updates on the same edge as the state transition that defines it.
- WAIT_LOCK: `cpu_rst` = 1. When `locked_s` = 1 → SETTLE, counter cleared.
- SETTLE: counter increments each cycle.
  - `locked_s` = 0 → WAIT_LOCK.
  - Counter = SETTLE_CYCLES−1 → HOLD, counter cleared.
- HOLD: `cpu_rst` = 1, counter increments each cycle.
  - Counter = HOLD_CYCLES−1 → RUN; `cpu_rst` goes to 0 on that edge.
  - `locked_s` = 0 → WAIT_LOCK with cause 3.
- RUN: `cpu_rst` = 0.
  - `locked_s` = 0 → WAIT_LOCK; `cpu_rst` = 1 and `rst_cause` = 3 on the same edge.
  - Otherwise, `reset_req` & `reset_en_s` → DRAIN; `drain` = 1, counter cleared.
- DRAIN: `cpu_rst` stays 0, `drain` = 1.
  - `tx_idle` = 1, or counter = DRAIN_CYCLES−1 → HOLD.
  - On that edge: `cpu_rst` = 1, `drain` = 0, `rst_cause` = 2, `rst_count` += 1, saturating at 255.
  - `locked_s` = 0 has priority → WAIT_LOCK with cause 3; `rst_count` unchanged.
- Power-on timing: if `pll_locked` is set before edge k, `locked_s` = 1 after edge k+SYNC_STAGES−1. State is SETTLE from edge k+SYNC_STAGES. `cpu_rst` falls at edge k+SYNC_STAGES+SETTLE_CYCLES+HOLD_CYCLES.
- `reset_req` outside RUN is dropped; it is not queued.
- `reset_req` in RUN with `reset_en_s` = 0 is dropped.
- A lock loss and a `reset_req` on the same edge → lock loss wins.
- Because `drain` is registered, `tx_idle` is sampled from the first DRAIN cycle. Minimum DRAIN dwell is 1 cycle.
- `rst_cause` holds its value until the next reset event.

Decomposition:
- Package `reset_seq_pkg`:
  - State encoding: WAIT_LOCK = 0, SETTLE = 1, HOLD = 2, RUN = 3, DRAIN = 4 (3-bit).
  - Cause constants: CAUSE_POR = 1, CAUSE_BTN = 2, CAUSE_LOCK = 3.
- One sub-module, `sync_ff`: parameterized WIDTH/STAGES flop chain, async-reset to 0. Instantiated once with WIDTH = 2, for `pll_locked` and `reset_en`.
- FSM, counter and output registers live in `reset_sequencer`.

Test Plan:
All scenarios use SETTLE_CYCLES = 4, HOLD_CYCLES = 3, DRAIN_CYCLES = 10, SYNC_STAGES = 2.
- Power-up: release `rst_n`, set `pll_locked` = 1 before edge k → `cpu_rst` falls exactly at edge k+9. `rst_cause` = 1, `drain` stays 0.
- Button reset, idle UART: in RUN, `reset_en` = 1, `tx_idle` = 1, pulse `reset_req` → `drain` = 1 for 1 cycle, then `cpu_rst` = 1 for 3 cycles, then 0. `rst_cause` = 2, `rst_count` = 1.
- Drain timeout: `tx_idle` held 0 and `reset_req` pulsed → `drain` high exactly 10 cycles, then 3 cycles of `cpu_rst`, `rst_count` + 1. If `tx_idle` rises after 4 cycles instead, `drain` lasts 5 cycles.
- Gated request: `reset_en` = 0, pulse `reset_req` in RUN; also pulse it during SETTLE with `reset_en` = 1 → `cpu_rst` stays 0, `rst_count` unchanged in both cases.
- Lock loss: drop `pll_locked` in DRAIN, and separately in RUN on the same cycle as `reset_req` → WAIT_LOCK, `cpu_rst` = 1, `rst_cause` = 3, `rst_count` unchanged. Relocking repeats the 9-edge sequence.
- Saturation and async reset: 256 button resets → `rst_count` = 255 and stays there. Asserting `rst_n` mid-HOLD between edges → `cpu_rst` = 1, `rst_count` = 0, `rst_cause` = 1 immediately.
